// File: rtl/load_store_unit.sv
// Load/store unit between the EX-stage ALU result and a word-only data memory.
// Sub-word stores use read-modify-write; sub-word loads are sign/zero-extended.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned IDX_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [31:0]      address,
  input  logic [31:0]      write_data,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [1:0]       mem_size,
  input  logic             mem_unsigned,
  output logic             stall,
  output logic             done,
  output logic [31:0]      load_data,
  output logic             fault,
  output logic             mem_req,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

  state_t      state, state_nx;
  logic        accept, illegal, start;
  logic [1:0]  off_q, size_q;
  logic        uns_q;
  logic [15:0] wdata_q;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ext_data, merged;

  assign accept = (state == IDLE) && req_valid && (MemRead || MemWrite);
  assign start  = accept && !illegal;

  always_comb begin
    illegal = 1'b0;
    if (MemRead && MemWrite) illegal = 1'b1;
    case (mem_size)
      2'b01:   if (address[0]) illegal = 1'b1;
      2'b10:   if (address[1:0] != 2'b00) illegal = 1'b1;
      2'b11:   illegal = 1'b1;
      default: ;
    endcase
    if ({2'b00, address[31:2]} >= 32'(MEM_WORDS)) illegal = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) begin
        if (MemRead)                state_nx = RD;
        else if (mem_size == 2'b10) state_nx = WR;
        else                        state_nx = RMW_RD;
      end
      RD:      if (mem_ready) state_nx = RESP;
      RMW_RD:  if (mem_ready) state_nx = WR;
      WR:      if (mem_ready) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control outputs decode the state register directly, so they drop with async reset.
  assign mem_req = (state == RD) || (state == RMW_RD) || (state == WR);
  assign mem_we  = (state == WR);
  assign done    = (state == RESP);
  assign stall   = (state != IDLE);

  // Big-endian lanes: byte offset 0 is [31:24], half offset 0 is [31:16].
  always_comb begin
    case (off_q)
      2'd0:    rd_byte = mem_rdata[31:24];
      2'd1:    rd_byte = mem_rdata[23:16];
      2'd2:    rd_byte = mem_rdata[15:8];
      default: rd_byte = mem_rdata[7:0];
    endcase
    rd_half = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (size_q)
      2'b00:   ext_data = uns_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   ext_data = uns_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: ext_data = mem_rdata;
    endcase
    merged = mem_rdata;
    if (size_q == 2'b00) begin
      case (off_q)
        2'd0:    merged[31:24] = wdata_q[7:0];
        2'd1:    merged[23:16] = wdata_q[7:0];
        2'd2:    merged[15:8]  = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[15:0] = wdata_q;
    end else begin
      merged[31:16] = wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault     <= 1'b0;
      load_data <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      off_q     <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      wdata_q   <= '0;
    end else begin
      fault <= accept && illegal;
      if (start) begin
        mem_addr <= address[IDX_W+1:2];
        off_q    <= address[1:0];
        size_q   <= mem_size;
        uns_q    <= mem_unsigned;
        wdata_q  <= write_data[15:0];
        if (mem_size == 2'b10) mem_wdata <= write_data;
      end
      if (state == RD && mem_ready)     load_data <= ext_data;
      if (state == RMW_RD && mem_ready) mem_wdata <= merged;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a word memory model and configurable wait states.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, MemRead, MemWrite, mem_unsigned;
  logic [31:0] address, write_data;
  logic [1:0]  mem_size;
  logic        stall, done, fault, mem_req, mem_we, mem_ready;
  logic [31:0] load_data, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;

  load_store_unit #(.MEM_WORDS(256), .IDX_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .address(address),
    .write_data(write_data), .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .stall(stall),
    .done(done), .load_data(load_data), .fault(fault), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Memory model
  logic [31:0] mem [256];
  int unsigned wait_cfg = 0, wait_left = 0;
  int unsigned n_reads = 0, n_writes = 0;
  logic [7:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;

  assign mem_ready = mem_req && (wait_left == 0);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk or negedge rst) begin
    if (!rst) wait_left <= wait_cfg;
    else if (mem_req) begin
      if (wait_left == 0) begin
        wait_left <= wait_cfg;
        if (mem_we) begin
          mem[mem_addr] <= mem_wdata;
          n_writes      <= n_writes + 1;
          last_waddr    <= mem_addr;
          last_wdata    <= mem_wdata;
        end else n_reads <= n_reads + 1;
      end else wait_left <= wait_left - 1;
    end else wait_left <= wait_cfg;
  end

  int n_checks = 0, n_pass = 0;
  function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
  endfunction

  typedef struct { logic is_fault; logic chk_data; logic [31:0] data; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  // Monitor: handshake stability and response scoreboard
  logic        prev_req = 1'b0, prev_xfer = 1'b0, prev_we = 1'b0;
  logic [7:0]  prev_addr = '0;
  logic [31:0] prev_wdata = '0;
  int unsigned n_req_cycles = 0;

  always @(negedge clk) begin
    if (!rst) prev_req = 1'b0;
    else begin
      if (mem_req) n_req_cycles++;
      if (mem_req && prev_req && !prev_xfer) begin
        check("hold_addr_we", {23'b0, mem_we, mem_addr}, {23'b0, prev_we, prev_addr});
        check("hold_wdata", mem_wdata, prev_wdata);
      end
      if (done || fault) begin
        if (sb_q.size() == 0) check("unexpected_resp", {30'b0, fault, done}, 32'h0);
        else begin
          mon_e = sb_q.pop_front();
          check("resp_fault", 32'(fault), 32'(mon_e.is_fault));
          check("resp_done", 32'(done), 32'(!mon_e.is_fault));
          if (mon_e.is_fault) check("fault_stall", 32'(stall), 32'h0);
          if (mon_e.chk_data) check("load_data", load_data, mon_e.data);
        end
      end
      prev_req   = mem_req;
      prev_xfer  = mem_req && mem_ready;
      prev_we    = mem_we;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, output int lat);
    req_valid = 1'b1; MemRead = rd; MemWrite = wr; mem_size = sz;
    mem_unsigned = uns; address = a; write_data = wd;
    @(posedge clk); #1;
    lat = 1;
    req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    while (!(done || fault) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!(done || fault)) lat = -1;
    @(posedge clk); #1;
  endtask

  task automatic run(input string nm, input logic rd, input logic wr, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a, input logic [31:0] wd,
                     input logic isf, input logic chk, input logic [31:0] ed, input int exp_lat);
    exp_t e;
    int lat;
    e.is_fault = isf; e.chk_data = chk; e.data = ed;
    sb_q.push_back(e);
    do_req(rd, wr, sz, uns, a, wd, lat);
    check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_ctrl"}, {27'b0, stall, done, fault, mem_req, mem_we}, 32'h0);
    check({nm, "_addr"}, {24'b0, mem_addr}, 32'h0);
    check({nm, "_ldata"}, load_data, 32'h0);
    check({nm, "_wdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    int unsigned w0, r0, q0;
    exp_t e;
    rst = 1'b0; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    mem_size = 2'b00; mem_unsigned = 1'b0; address = '0; write_data = '0;
    @(posedge clk); #1;
    check_idle_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Word round trip
    w0 = n_writes;
    run("sw_word", 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 2);
    check("sw_nwrites", n_writes - w0, 1);
    check("sw_waddr", {24'b0, last_waddr}, 32'h4);
    check("sw_wdata", last_wdata, 32'hDEADBEEF);
    run("lw_word", 1, 0, 2'b10, 0, 32'h10, 0, 0, 1, 32'hDEADBEEF, 2);

    // Load extension on 0x1280FF7F
    run("sw_pat", 0, 1, 2'b10, 0, 32'h10, 32'h1280FF7F, 0, 0, 0, 2);
    run("lb_11",  1, 0, 2'b00, 0, 32'h11, 0, 0, 1, 32'hFFFFFF80, 2);
    run("lbu_11", 1, 0, 2'b00, 1, 32'h11, 0, 0, 1, 32'h00000080, 2);
    run("lb_13",  1, 0, 2'b00, 0, 32'h13, 0, 0, 1, 32'h0000007F, 2);
    run("lh_12",  1, 0, 2'b01, 0, 32'h12, 0, 0, 1, 32'hFFFFFF7F, 2);
    run("lhu_10", 1, 0, 2'b01, 1, 32'h10, 0, 0, 1, 32'h00001280, 2);
    run("lh_10",  1, 0, 2'b01, 0, 32'h10, 0, 0, 1, 32'h00001280, 2);
    run("lw_uns", 1, 0, 2'b10, 1, 32'h10, 0, 0, 1, 32'h1280FF7F, 2);

    // Sub-word store read-modify-write, zero wait
    run("sw_aabb", 0, 1, 2'b10, 0, 32'h10, 32'hAABBCCDD, 0, 0, 0, 2);
    w0 = n_writes; r0 = n_reads;
    run("sb_12", 0, 1, 2'b00, 0, 32'h12, 32'h00000011, 0, 0, 0, 3);
    check("sb_nreads", n_reads - r0, 1);
    check("sb_nwrites", n_writes - w0, 1);
    check("sb_wdata", last_wdata, 32'hAABB11DD);
    run("lw_sb", 1, 0, 2'b10, 0, 32'h10, 0, 0, 1, 32'hAABB11DD, 2);

    // Same with two wait cycles per phase
    run("sw_aabb2", 0, 1, 2'b10, 0, 32'h10, 32'hAABBCCDD, 0, 0, 0, 2);
    wait_cfg = 2;
    @(posedge clk); #1;
    w0 = n_writes; r0 = n_reads;
    run("sb_12_wait", 0, 1, 2'b00, 0, 32'h12, 32'h00000011, 0, 0, 0, 7);
    check("sbw_nreads", n_reads - r0, 1);
    check("sbw_nwrites", n_writes - w0, 1);
    check("sbw_wdata", last_wdata, 32'hAABB11DD);
    run("sw_wait", 0, 1, 2'b10, 0, 32'h14, 32'h01020304, 0, 0, 0, 4);
    wait_cfg = 0;
    @(posedge clk); #1;
    run("sh_16", 0, 1, 2'b01, 0, 32'h16, 32'h12345678, 0, 0, 0, 3);
    check("sh_wdata", last_wdata, 32'h01025678);
    run("sb_14", 0, 1, 2'b00, 0, 32'h14, 32'hFFFFFFAB, 0, 0, 0, 3);
    check("sb14_wdata", last_wdata, 32'hAB025678);
    run("lw_14", 1, 0, 2'b10, 0, 32'h14, 0, 0, 1, 32'hAB025678, 2);

    // Faults: one-cycle pulse, no memory traffic
    q0 = n_req_cycles;
    run("f_lw_13",  1, 0, 2'b10, 0, 32'h13,  0, 1, 0, 0, 1);
    run("f_sh_05",  0, 1, 2'b01, 0, 32'h05,  32'h1234, 1, 0, 0, 1);
    run("f_range",  1, 0, 2'b10, 0, 32'h400, 0, 1, 0, 0, 1);
    run("f_rdwr",   1, 1, 2'b10, 0, 32'h10,  0, 1, 0, 0, 1);
    run("f_size11", 1, 0, 2'b11, 0, 32'h10,  0, 1, 0, 0, 1);
    check("fault_noreq", n_req_cycles - q0, 0);
    check("ldata_held", load_data, 32'hAB025678);

    // req_valid without MemRead/MemWrite is ignored
    req_valid = 1'b1; address = 32'h10; mem_size = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("ignored", {28'b0, stall, done, fault, mem_req}, 32'h0);
    end

    // Back-to-back loads with req_valid held
    run("sw_20", 0, 1, 2'b10, 0, 32'h20, 32'h11111111, 0, 0, 0, 2);
    run("sw_24", 0, 1, 2'b10, 0, 32'h24, 32'h22222222, 0, 0, 0, 2);
    e.is_fault = 0; e.chk_data = 1;
    e.data = 32'h11111111; sb_q.push_back(e);
    e.data = 32'h22222222; sb_q.push_back(e);
    req_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; mem_size = 2'b10;
    mem_unsigned = 1'b0; address = 32'h20;
    @(posedge clk); #1;
    check("b2b_first", {23'b0, stall, mem_addr}, {23'b0, 1'b1, 8'h08});
    address = 32'h24;
    @(posedge clk); #1;
    check("b2b_done1", {23'b0, done, mem_addr}, {23'b0, 1'b1, 8'h08});
    @(posedge clk); #1;
    check("b2b_not_in_resp", 32'(stall), 32'h0);
    @(posedge clk); #1;
    check("b2b_second", {23'b0, stall, mem_addr}, {23'b0, 1'b1, 8'h09});
    req_valid = 1'b0; MemRead = 1'b0;
    @(posedge clk); #1;
    check("b2b_done2", 32'(done), 32'h1);
    @(posedge clk); #1;

    // Reset in the middle of a held read
    wait_cfg = 5;
    @(posedge clk); #1;
    req_valid = 1'b1; MemRead = 1'b1; mem_size = 2'b10; address = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0; MemRead = 1'b0;
    @(posedge clk); #1;
    check("mid_rd_req", {30'b0, stall, mem_req}, 32'h3);
    #2 rst = 1'b0;
    #1 check("async_drop", {29'b0, stall, done, mem_req}, 32'h0);
    wait_cfg = 0;
    @(posedge clk); #1;
    check_idle_outputs("in_reset");
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("post_reset");
    run("lw_recover", 1, 0, 2'b10, 0, 32'h20, 0, 0, 1, 32'h11111111, 2);

    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
